// File: rtl/debug_cmd_deframer.sv
// rtl/debug_cmd_deframer.sv - assembles UART bytes into opcode + little-endian payload debug commands
module debug_cmd_deframer #(
    parameter logic [7:0] OP_WRITE_PC       = 8'h07,
    parameter logic [7:0] OP_READ_REGISTER  = 8'h08,
    parameter logic [7:0] OP_WRITE_REGISTER = 8'h09,
    parameter int         TIMEOUT_CLKS      = 1000000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Cmd_Valid,
    input  logic        i_Cmd_Ready,
    output logic [7:0]  o_Cmd_Opcode,
    output logic [4:0]  o_Cmd_Reg_Addr,
    output logic [31:0] o_Cmd_Data,
    output logic        o_Frame_Error,
    output logic        o_Overrun,
    output logic        o_Busy
);

    localparam int TW = $clog2(TIMEOUT_CLKS);
    // Expiry fires on the edge where the counter would reach TIMEOUT_CLKS-1.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 2);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_OUTPUT} state_t;

    state_t        state;
    logic [2:0]    payload_len;
    logic [2:0]    byte_idx;
    logic [TW-1:0] timeout_cnt;
    logic [1:0]    data_idx;
    logic          is_reg_op;
    logic          handshake;
    logic          take_opcode;

    function automatic logic [2:0] payload_len_of(input logic [7:0] op);
        if (op == OP_WRITE_PC)       return 3'd4;
        if (op == OP_READ_REGISTER)  return 3'd1;
        if (op == OP_WRITE_REGISTER) return 3'd5;
        return 3'd0;
    endfunction

    assign is_reg_op   = (o_Cmd_Opcode == OP_READ_REGISTER) || (o_Cmd_Opcode == OP_WRITE_REGISTER);
    assign handshake   = (state == S_OUTPUT) && o_Cmd_Valid && i_Cmd_Ready;
    // A byte in the handshake cycle starts the next frame so back-to-back commands survive.
    assign take_opcode = i_Rx_DV && ((state == S_IDLE) || handshake);
    assign data_idx    = is_reg_op ? 2'(byte_idx - 3'd1) : byte_idx[1:0];
    assign o_Busy      = (state != S_IDLE);

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state          <= S_IDLE;
            payload_len    <= '0;
            byte_idx       <= '0;
            timeout_cnt    <= '0;
            o_Cmd_Valid    <= 1'b0;
            o_Cmd_Opcode   <= '0;
            o_Cmd_Reg_Addr <= '0;
            o_Cmd_Data     <= '0;
            o_Frame_Error  <= 1'b0;
            o_Overrun      <= 1'b0;
        end else begin
            o_Frame_Error <= 1'b0;
            o_Overrun     <= 1'b0;
            if (take_opcode) begin
                o_Cmd_Opcode   <= i_Rx_Byte;
                o_Cmd_Reg_Addr <= '0;
                o_Cmd_Data     <= '0;
                payload_len    <= payload_len_of(i_Rx_Byte);
                byte_idx       <= '0;
                timeout_cnt    <= '0;
                if (payload_len_of(i_Rx_Byte) == 3'd0) begin
                    state       <= S_OUTPUT;
                    o_Cmd_Valid <= 1'b1;
                end else begin
                    state       <= S_PAYLOAD;
                    o_Cmd_Valid <= 1'b0;
                end
            end else begin
                case (state)
                    S_PAYLOAD: begin
                        if (i_Rx_DV) begin
                            timeout_cnt <= '0;
                            if (is_reg_op && byte_idx == 3'd0 && i_Rx_Byte[7:5] != 3'd0) begin
                                o_Frame_Error  <= 1'b1;
                                state          <= S_IDLE;
                                o_Cmd_Reg_Addr <= '0;
                                o_Cmd_Data     <= '0;
                            end else begin
                                if (is_reg_op && byte_idx == 3'd0) begin
                                    o_Cmd_Reg_Addr <= i_Rx_Byte[4:0];
                                end else begin
                                    case (data_idx)
                                        2'd0:    o_Cmd_Data[7:0]   <= i_Rx_Byte;
                                        2'd1:    o_Cmd_Data[15:8]  <= i_Rx_Byte;
                                        2'd2:    o_Cmd_Data[23:16] <= i_Rx_Byte;
                                        default: o_Cmd_Data[31:24] <= i_Rx_Byte;
                                    endcase
                                end
                                if (byte_idx == payload_len - 3'd1) begin
                                    state       <= S_OUTPUT;
                                    o_Cmd_Valid <= 1'b1;
                                end else begin
                                    byte_idx <= byte_idx + 3'd1;
                                end
                            end
                        end else if (timeout_cnt == TIMEOUT_LAST) begin
                            o_Frame_Error  <= 1'b1;
                            state          <= S_IDLE;
                            o_Cmd_Reg_Addr <= '0;
                            o_Cmd_Data     <= '0;
                        end else begin
                            timeout_cnt <= timeout_cnt + TW'(1);
                        end
                    end
                    S_OUTPUT: begin
                        if (handshake) begin
                            o_Cmd_Valid <= 1'b0;
                            state       <= S_IDLE;
                        end else if (i_Rx_DV) begin
                            o_Overrun <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_deframer.sv
// tb/tb_debug_cmd_deframer.sv - directed and randomized checks of debug_cmd_deframer
module tb_debug_cmd_deframer;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [7:0]  rxb;
    logic        ready;
    logic        valid;
    logic [7:0]  op;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ferr;
    logic        ovr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    debug_cmd_deframer #(.TIMEOUT_CLKS(TO)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(dv), .i_Rx_Byte(rxb),
        .o_Cmd_Valid(valid), .i_Cmd_Ready(ready), .o_Cmd_Opcode(op),
        .o_Cmd_Reg_Addr(addr), .o_Cmd_Data(data), .o_Frame_Error(ferr),
        .o_Overrun(ovr), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    logic        mon_en = 1'b0;
    logic [44:0] obs_q[$];
    int          obs_err = 0;
    int          obs_ovr = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid && ready) obs_q.push_back({op, addr, data});
            if (ferr) obs_err++;
            if (ovr) obs_ovr++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        dv  = 1'b1;
        rxb = b;
        @(negedge clk);
        dv  = 1'b0;
    endtask

    function automatic int len_of(input logic [7:0] o);
        return (o == 8'h07) ? 4 : (o == 8'h08) ? 1 : (o == 8'h09) ? 5 : 0;
    endfunction

    initial begin : main
        int          vcount;
        int          first;
        int          pulses;
        logic        stable;
        logic [7:0]  sb[$];
        int          sg[$];
        logic [44:0] exp_q[$];
        int          exp_err;

        rst = 1'b1; dv = 1'b0; rxb = 8'h00; ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {valid, op, addr, data, ferr, ovr, busy}, 64'd0);
        rst = 1'b0;

        // Zero-payload command, consumed immediately.
        send(8'h05);
        chk("ping_valid", valid, 1);
        chk("ping_fields", {op, addr, data}, {8'h05, 5'd0, 32'd0});
        @(negedge clk);
        chk("ping_valid_drop", valid, 0);

        // WRITE_REGISTER held under backpressure.
        ready = 1'b0;
        send(8'h09); send(8'h1F); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        vcount = 0; stable = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (valid) vcount++;
            if ({op, addr, data} !== {8'h09, 5'h1F, 32'hDEADBEEF}) stable = 1'b0;
            if (i == 20) ready = 1'b1;
            @(negedge clk);
        end
        chk("wreg_valid_cycles", vcount, 21);
        chk("wreg_stable", stable, 1);
        chk("wreg_valid_drop", valid, 0);

        // Inter-byte timeout.
        send(8'h07); send(8'h11); send(8'h22);
        first = 0; pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            if (ferr) begin
                pulses++;
                if (first == 0) first = k;
            end
            @(negedge clk);
        end
        chk("timeout_cycle", first, 16);
        chk("timeout_pulses", pulses, 1);
        chk("timeout_busy", busy, 0);
        send(8'h05);
        chk("post_timeout_cmd", {valid, op, addr, data}, {1'b1, 8'h05, 5'd0, 32'd0});
        @(negedge clk);

        // Bad register address, then good one.
        send(8'h08); send(8'h20);
        chk("badaddr_err", {ferr, valid}, 2'b10);
        @(negedge clk);
        chk("badaddr_err_drop", ferr, 0);
        send(8'h08); send(8'h03);
        chk("rdreg_cmd", {valid, op, addr, data}, {1'b1, 8'h08, 5'h03, 32'd0});
        @(negedge clk);

        // Overrun while pending, then byte during handshake.
        ready = 1'b0;
        send(8'h0A);
        chk("pend_valid", valid, 1);
        send(8'h05);
        chk("overrun_pulse", {ovr, valid, op}, {1'b1, 1'b1, 8'h0A});
        @(negedge clk);
        chk("overrun_drop", ovr, 0);
        dv = 1'b1; rxb = 8'h0B; ready = 1'b1;
        @(negedge clk);
        dv = 1'b0; ready = 1'b0;
        chk("b2b_second", {valid, op, ovr}, {1'b1, 8'h0B, 1'b0});
        ready = 1'b1;
        @(negedge clk);
        chk("b2b_consumed", valid, 0);

        // Asynchronous reset mid-frame.
        send(8'h07); send(8'h11); send(8'h22); send(8'h33);
        chk("midframe_busy", busy, 1);
        #2 rst = 1'b1;
        #1 chk("async_reset", {valid, op, addr, data, ferr, ovr, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h05);
        chk("post_reset_cmd", {valid, op, addr, data}, {1'b1, 8'h05, 5'd0, 32'd0});
        @(negedge clk);

        // Randomized frames with random gaps, ready held high.
        for (int f = 0; f < 40; f++) begin
            int          r;
            logic [7:0]  o;
            r = $urandom_range(0, 4);
            o = (r == 0) ? 8'h07 : (r == 1) ? 8'h08 : (r == 2) ? 8'h09 : (r == 3) ? 8'($urandom) : 8'h05;
            sb.push_back(o);
            for (int j = 0; j < len_of(o); j++) begin
                if (j == 0 && (o == 8'h08 || o == 8'h09))
                    sb.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : {3'b000, 5'($urandom)});
                else
                    sb.push_back(8'($urandom));
            end
        end
        foreach (sb[i]) sg.push_back(($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(1, 12)));

        // Reference: parse the byte stream frame by frame.
        exp_err = 0;
        begin : model
            bit          in_pl;
            int          need;
            int          idx;
            logic [7:0]  mop;
            logic [4:0]  maddr;
            logic [31:0] mdata;
            bit          isreg;
            in_pl = 0; need = 0; idx = 0; mop = 0; maddr = 0; mdata = 0;
            foreach (sb[i]) begin
                if (in_pl && sg[i] > TO - 1) begin
                    exp_err++;
                    in_pl = 0;
                end
                if (!in_pl) begin
                    mop = sb[i]; maddr = 0; mdata = 0; idx = 0; need = len_of(sb[i]);
                    if (need == 0) exp_q.push_back({mop, maddr, mdata});
                    else in_pl = 1;
                end else begin
                    isreg = (mop == 8'h08 || mop == 8'h09);
                    if (isreg && idx == 0) begin
                        if (sb[i][7:5] != 3'd0) begin
                            exp_err++;
                            in_pl = 0;
                        end else maddr = sb[i][4:0];
                    end else begin
                        mdata[8 * (isreg ? idx - 1 : idx) +: 8] = sb[i];
                    end
                    if (in_pl) begin
                        idx++;
                        if (idx == need) begin
                            exp_q.push_back({mop, maddr, mdata});
                            in_pl = 0;
                        end
                    end
                end
            end
            if (in_pl) exp_err++;
        end

        ready  = 1'b1;
        mon_en = 1'b1;
        foreach (sb[i]) begin
            for (int k = 1; k < sg[i]; k++) begin
                @(negedge clk);
                dv = 1'b0;
            end
            @(negedge clk);
            dv  = 1'b1;
            rxb = sb[i];
        end
        @(negedge clk);
        dv = 1'b0;
        repeat (40) @(negedge clk);
        mon_en = 1'b0;

        chk("rand_cmd_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("rand_cmd_%0d", i), obs_q[i], exp_q[i]);
        chk("rand_frame_errors", obs_err, exp_err);
        chk("rand_overruns", obs_ovr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_cmd_deframer.md
Name: debug_cmd_deframer

Overview:
- Sits between uart_receiver and the debug peripheral command engine.
- Assembles a multi-byte debug command from received UART bytes: one opcode byte, then an opcode-dependent little-endian payload.
- Presents each complete command as one parallel word under a valid/ready handshake.
- Enforces an inter-byte timeout and reports framing errors and overruns.

Parameters:
- OP_WRITE_PC, 8'h07, opcode carrying a 4-byte data payload.
- OP_READ_REGISTER, 8'h08, opcode carrying a 1-byte register-address payload.
- OP_WRITE_REGISTER, 8'h09, opcode carrying a 1-byte register address, then a 4-byte data payload.
- TIMEOUT_CLKS, 1000000, max clocks between payload bytes before the frame is discarded (>=2).

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Rx_DV  in  1  one-cycle strobe, received byte valid
- i_Rx_Byte  in  8  received byte
- o_Cmd_Valid  out  1  complete command available
- i_Cmd_Ready  in  1  consumer accepts command when high with o_Cmd_Valid
- o_Cmd_Opcode  out  8  command opcode
- o_Cmd_Reg_Addr  out  5  register address (register opcodes only, else 0)
- o_Cmd_Data  out  32  data payload, little-endian (write opcodes only, else 0)
- o_Frame_Error  out  1  one-cycle pulse: frame discarded
- o_Overrun  out  1  one-cycle pulse: byte dropped while command pending
- o_Busy  out  1  high in S_PAYLOAD or S_OUTPUT

Behaviour:
- Clock and reset: reset i_Reset, asynchronous, active-high; clock i_Clock.
- Reset values: all outputs 0, state S_IDLE, byte counter 0, timeout counter 0.
- Reset mid-frame or mid-handshake discards everything immediately.
- Payload length by opcode: WRITE_PC 4, READ_REGISTER 1, WRITE_REGISTER 5, any other opcode 0.
- S_IDLE:
  - On i_Rx_DV, latch opcode and clear the data and address fields.
  - Payload length 0 -> go to S_OUTPUT, so o_Cmd_Valid rises the cycle after the strobe.
  - Otherwise -> go to S_PAYLOAD with byte index 0 and timeout counter 0.
- S_PAYLOAD, on each i_Rx_DV:
  - Register opcodes: index 0 is the register address. If bits [7:5] are nonzero, pulse o_Frame_Error and return to S_IDLE. Otherwise store bits [4:0].
  - Data bytes fill o_Cmd_Data in order [7:0], [15:8], [23:16], [31:24].
  - After the last byte, go to S_OUTPUT; o_Cmd_Valid is high the next cycle.
  - Timeout counter clears on every byte and increments otherwise.
  - When it reaches TIMEOUT_CLKS-1 with no byte that cycle: pulse o_Frame_Error, return to S_IDLE, discard partial data.
  - A byte arriving in the expiry cycle wins: it is accepted, no error.
- S_OUTPUT:
  - o_Cmd_Valid is high; opcode, address and data are held stable until the handshake.
  - On o_Cmd_Valid && i_Cmd_Ready, o_Cmd_Valid drops next cycle and the state returns to S_IDLE.
  - i_Rx_DV in the handshake cycle is treated as a new opcode, as in S_IDLE, so back-to-back commands are not lost.
  - i_Rx_DV in any other S_OUTPUT cycle: byte dropped, o_Overrun pulses for one cycle, command unchanged.
- No timeout runs in S_IDLE or S_OUTPUT.
- o_Frame_Error and o_Overrun never assert in the same cycle as a state change into S_OUTPUT.
- Unknown opcodes are passed through with zero payload; decoding them is the consumer's job.

Test Plan:
- Reset, then byte 8'h05 with i_Cmd_Ready=1 -> o_Cmd_Valid high for exactly 1 cycle, one clock after the strobe; opcode 05, address 0, data 0.
- Bytes 09,1F,EF,BE,AD,DE, i_Cmd_Ready=0 for 20 cycles, then 1 -> valid held 21 cycles, opcode 09, address 1F, data DEADBEEF, stable throughout.
- Bytes 07,11,22 then silence with TIMEOUT_CLKS=16 -> o_Frame_Error single pulse 15 cycles after byte 22; o_Busy low after; next byte 05 yields a clean PING command.
- Bytes 08,20 -> o_Frame_Error pulse, no o_Cmd_Valid; then 08,03 -> opcode 08, address 03.
- Pending command, ready=0, byte 05 arrives -> o_Overrun pulse, command unchanged. Then a byte arrives in the same cycle as ready=1 -> first command consumed, second command valid on the following cycle.
- Reset asserted asynchronously after byte 3 of a WRITE_PC frame -> all outputs 0 immediately. After release, 05 decodes normally with no stale data.
